// File: rtl/pll_scan_loader.sv
// PLL scan loader: reads a CHAIN_LEN-bit image from the serial ROM, then shifts it into the PLL scan chain on `reconfig`.
// Latency: CHAIN_LEN+ROM_LATENCY cycles to load, 2*CHAIN_LEN cycles to shift, then 1 update cycle and a wait for scandone.
// Backpressure: none; `start` is ignored while busy, and `PLL_SCAN_TIMEOUT_EN` bounds both wait states.
module pll_scan_loader #(
    parameter int CHAIN_LEN      = 144,
    parameter int ADDR_WIDTH     = 8,
    parameter int ROM_LATENCY    = 2,
    parameter int RECONF_TIMEOUT = 16,
    parameter int DONE_TIMEOUT   = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  reconfig,
    input  logic                  rom_q,
    input  logic                  scandone,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_read_ena,
    output logic                  busy,
    output logic                  scanclk,
    output logic                  scanclkena,
    output logic                  scandata,
    output logic                  configupdate,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT_RECONF, SHIFT, UPDATE, WAIT_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_BIT   = ADDR_WIDTH'(CHAIN_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(ROM_LATENCY - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   bit_cnt;
    logic                    shift_phase;
    logic                    reconf_pend;
    logic                    scandone_seen;
    logic [CHAIN_LEN-1:0]    chain_buf;
    logic [ROM_LATENCY-1:0]  cap_vld;
    logic [ADDR_WIDTH-1:0]   cap_addr [ROM_LATENCY];

`ifdef PLL_SCAN_TIMEOUT_EN
    localparam int TMO_W = $clog2((DONE_TIMEOUT > RECONF_TIMEOUT) ? DONE_TIMEOUT : RECONF_TIMEOUT) + 1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // The read strobe and address travel alongside the ROM pipeline so each bit lands at its own address.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cap_vld <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) cap_addr[i] <= '0;
        end else begin
            cap_vld[0]  <= rom_read_ena;
            cap_addr[0] <= rom_address;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                cap_vld[i]  <= cap_vld[i-1];
                cap_addr[i] <= cap_addr[i-1];
            end
        end
    end

    // Image buffer deliberately survives reset and keeps the previous image until overwritten.
    always_ff @(posedge clock) begin
        if (cap_vld[ROM_LATENCY-1]) chain_buf[cap_addr[ROM_LATENCY-1]] <= rom_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            rom_address   <= '0;
            rom_read_ena  <= 1'b0;
            busy          <= 1'b0;
            scanclk       <= 1'b0;
            scanclkena    <= 1'b0;
            scandata      <= 1'b0;
            configupdate  <= 1'b0;
            done          <= 1'b0;
            bit_cnt       <= '0;
            shift_phase   <= 1'b0;
            reconf_pend   <= 1'b0;
            scandone_seen <= 1'b0;
`ifdef PLL_SCAN_TIMEOUT_EN
            tmo_cnt       <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            done         <= 1'b0;
            configupdate <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state        <= READ;
                    busy         <= 1'b1;
                    rom_address  <= '0;
                    rom_read_ena <= 1'b1;
                    reconf_pend  <= 1'b0;
`ifdef PLL_SCAN_TIMEOUT_EN
                    error_q      <= 1'b0;
`endif
                end
                READ: begin
                    if (reconfig) reconf_pend <= 1'b1;
                    if (rom_address == LAST_BIT) begin
                        rom_read_ena <= 1'b0;
                        bit_cnt      <= '0;
                        state        <= DRAIN;
                    end else begin
                        rom_address <= rom_address + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (bit_cnt != DRAIN_LAST) begin
                        bit_cnt <= bit_cnt + ADDR_WIDTH'(1);
                        if (reconfig) reconf_pend <= 1'b1;
                    end else if (reconfig || reconf_pend) begin
                        // An early reconfig skips the wait and shifting starts straight away.
                        state       <= SHIFT;
                        reconf_pend <= 1'b0;
                        bit_cnt     <= '0;
                        shift_phase <= 1'b0;
                        scanclk     <= 1'b0;
                        scanclkena  <= 1'b1;
                        scandata    <= chain_buf[0];
                    end else begin
                        state <= WAIT_RECONF;
`ifdef PLL_SCAN_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                WAIT_RECONF: begin
                    if (reconfig) begin
                        state       <= SHIFT;
                        bit_cnt     <= '0;
                        shift_phase <= 1'b0;
                        scanclk     <= 1'b0;
                        scanclkena  <= 1'b1;
                        scandata    <= chain_buf[0];
                    end
`ifdef PLL_SCAN_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(RECONF_TIMEOUT - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                SHIFT: begin
                    if (!shift_phase) begin
                        scanclk     <= 1'b1;
                        shift_phase <= 1'b1;
                    end else if (bit_cnt == LAST_BIT) begin
                        scanclk      <= 1'b0;
                        scanclkena   <= 1'b0;
                        configupdate <= 1'b1;
                        state        <= UPDATE;
                    end else begin
                        scanclk     <= 1'b0;
                        shift_phase <= 1'b0;
                        bit_cnt     <= bit_cnt + ADDR_WIDTH'(1);
                        scandata    <= chain_buf[bit_cnt + ADDR_WIDTH'(1)];
                    end
                end
                UPDATE: begin
                    state         <= WAIT_DONE;
                    scandone_seen <= 1'b0;
`ifdef PLL_SCAN_TIMEOUT_EN
                    tmo_cnt       <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (scandone) scandone_seen <= 1'b1;
                    if (scandone_seen && !scandone) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`ifdef PLL_SCAN_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(DONE_TIMEOUT - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_scan_loader.sv
// Randomized bench for pll_scan_loader: a latency-accurate ROM model feeds random images, and the scan output is compared to the image.
module tb_pll_scan_loader;
    localparam int CL  = 144;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int RT  = 16;
    localparam int DT  = 1024;
    localparam int SHIFT_EARLIEST = CL + LAT + 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          reconfig = 1'b0;
    logic          rom_q = 1'b0;
    logic          scandone = 1'b0;
    logic [AW-1:0] rom_address;
    logic          rom_read_ena, busy, scanclk, scanclkena, scandata, configupdate, done, error;

    pll_scan_loader #(
        .CHAIN_LEN(CL), .ADDR_WIDTH(AW), .ROM_LATENCY(LAT),
        .RECONF_TIMEOUT(RT), .DONE_TIMEOUT(DT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .reconfig(reconfig),
        .rom_q(rom_q), .scandone(scandone), .rom_address(rom_address),
        .rom_read_ena(rom_read_ena), .busy(busy), .scanclk(scanclk),
        .scanclkena(scanclkena), .scandata(scandata), .configupdate(configupdate),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rel;
    logic [CL-1:0] rom_img;
    int          ah [LAT+1];
    bit          eh [LAT+1];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then the ROM answers the address issued LAT cycles earlier.
    task automatic step();
        @(negedge clock);
        rel++;
        for (int i = LAT; i > 0; i--) begin
            ah[i] = ah[i-1];
            eh[i] = eh[i-1];
        end
        ah[0] = int'(rom_address);
        eh[0] = rom_read_ena;
        rom_q = (eh[LAT] && ah[LAT] < CL) ? rom_img[ah[LAT]] : 1'($urandom);
    endtask

    task automatic rand_img(output logic [CL-1:0] img);
        for (int i = 0; i < CL; i++) img[i] = 1'($urandom);
    endtask

    task automatic run_seq(input logic [CL-1:0] img, input int rc, input int dup_start,
                           input int rst_bit, input int sd_dly, input bit sd_early);
        int ena_first = -1, ena_last = -1, ena_cnt = 0, addr_err = 0;
        int sck_first = -1, sck_last = -1, sck_cnt = 0, clk_err = 0, nbits = 0, bit_err = 0;
        int cu_cnt = 0, cu_cyc = -1, sd_rise = -1, sd_fall = -1;
        int done_cnt = 0, done_cyc = -1, busy_fall = -1, err_seen = 0, exp_first;
        bit fin = 0;
        rom_img = img;
        rel = 0;
        start = 1'b1;
        while (!fin) begin
            step();
            start = 1'b0;
            reconfig = 1'b0;
            if (rel == 1) chk("error_cleared_on_start", error, 0);
            if (rom_read_ena) begin
                if (ena_first < 0) ena_first = rel;
                ena_last = rel;
                ena_cnt++;
                if (int'(rom_address) != rel - 1) addr_err++;
            end
            if (busy_fall < 0 && !busy) busy_fall = rel;
            if (scanclkena) begin
                if (sck_first < 0) sck_first = rel;
                sck_last = rel;
                sck_cnt++;
                if (scanclk != ((rel - sck_first) % 2 == 1)) clk_err++;
                if (scanclk) begin
                    if (nbits < CL && scandata !== img[nbits]) bit_err++;
                    nbits++;
                end
            end
            if (configupdate) begin
                cu_cnt++;
                cu_cyc  = rel;
                sd_rise = sd_early ? rel : rel + sd_dly;
                sd_fall = sd_rise + 3;
            end
            if (done) begin
                done_cnt++;
                done_cyc = rel;
            end
            if (error) err_seen = 1;
            if (rel == dup_start) start = 1'b1;
            if (rel == rc) reconfig = 1'b1;
            scandone = (sd_early && sck_first >= 0 && rel >= sck_first + 10 && sd_fall < 0) ||
                       (sd_rise >= 0 && rel >= sd_rise && rel < sd_fall);
            if (rst_bit >= 0 && sck_cnt == 2 * rst_bit + 1) begin
                start = 1'b0; reconfig = 1'b0; scandone = 1'b0;
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
                chk("rst_bits_before_abort", nbits, rst_bit);
                chk("rst_scanclkena", scanclkena, 0);
                chk("rst_busy", busy, 0);
                chk("rst_scanclk", scanclk, 0);
                chk("rst_configupdate", configupdate, 0);
                return;
            end
            if (rc < 0 && rel == SHIFT_EARLIEST + RT + 4) fin = 1;
            if (done_cyc > 0 && rel == done_cyc + 1) fin = 1;
            if (!fin && rel >= 1500) begin
                chk("seq_completed_within_bound", done_cnt, 1);
                fin = 1;
            end
        end
        scandone = 1'b0;
        chk("ena_first", ena_first, 1);
        chk("ena_last", ena_last, CL);
        chk("ena_cnt", ena_cnt, CL);
        chk("addr_seq_err", addr_err, 0);
        if (rc < 0) begin
            chk("no_shift_without_reconfig", sck_cnt, 0);
            chk("no_done_without_reconfig", done_cnt, 0);
`ifdef PLL_SCAN_TIMEOUT_EN
            chk("tmo_busy_fall_cycle", busy_fall, SHIFT_EARLIEST + RT);
            chk("tmo_error_set", error, 1);
`else
            chk("wait_still_busy", busy, 1);
            chk("wait_error_low", err_seen, 0);
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            chk("wait_reset_busy", busy, 0);
`endif
        end else begin
            exp_first = (rc + 1 > SHIFT_EARLIEST) ? rc + 1 : SHIFT_EARLIEST;
            chk("shift_first_cycle", sck_first, exp_first);
            chk("shift_cycles", sck_cnt, 2 * CL);
            chk("shift_contiguous", sck_last - sck_first + 1, 2 * CL);
            chk("scanclk_pattern_err", clk_err, 0);
            chk("bits_shifted", nbits, CL);
            chk("scandata_err", bit_err, 0);
            chk("configupdate_cnt", cu_cnt, 1);
            chk("configupdate_cycle", cu_cyc, sck_last + 1);
            chk("done_cnt", done_cnt, 1);
            chk("done_cycle", done_cyc, sd_fall + 1);
            chk("busy_fall_cycle", busy_fall, done_cyc);
            chk("error_never", err_seen, 0);
        end
    endtask

    initial begin
        logic [CL-1:0] img;
        for (int i = 0; i <= LAT; i++) begin ah[i] = 0; eh[i] = 0; end
        reset_n = 1'b0;
        repeat (3) step();
        chk("reset_rom_address", rom_address, 0);
        chk("reset_rom_read_ena", rom_read_ena, 0);
        chk("reset_busy", busy, 0);
        chk("reset_scanclk", scanclk, 0);
        chk("reset_scanclkena", scanclkena, 0);
        chk("reset_scandata", scandata, 0);
        chk("reset_configupdate", configupdate, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        reset_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < CL; i++) img[i] = 1'(i % 2);
        run_seq(img, SHIFT_EARLIEST, -1, -1, 2, 1'b0);
        rand_img(img);
        run_seq(img, CL + 1, 50, -1, 1, 1'b1);
        rand_img(img);
        run_seq(img, CL + LAT, -1, -1, 4, 1'b0);
        rand_img(img);
        run_seq(img, SHIFT_EARLIEST + 5, -1, 70, 2, 1'b0);
        rand_img(img);
        run_seq(img, SHIFT_EARLIEST + 2, -1, -1, 3, 1'b0);

        start = 1'b1;
        reset_n = 1'b0;
        step();
        start = 1'b0;
        reset_n = 1'b1;
        chk("start_with_reset_busy", busy, 0);
        chk("start_with_reset_ena", rom_read_ena, 0);
        step();

        rand_img(img);
        run_seq(img, -1, -1, -1, 1, 1'b0);
        repeat (3) step();

        for (int n = 0; n < 3; n++) begin
            rand_img(img);
            run_seq(img, int'($urandom_range(CL + 1, SHIFT_EARLIEST + 30)),
                    int'($urandom_range(2, 400)), -1,
                    int'($urandom_range(1, 6)), 1'($urandom));
            repeat (int'($urandom_range(1, 4))) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
